mem_initiator: RTL and testbench

Bus initiator for the 32x8 single-port memory on the memory interface: accepts burst read and write commands on a valid/ready command port and sequences the memory's `write`/`read`/`addr`/`data_in` strobes. Write data arrives on a handshaked stream, and read data returns on a handshaked stream. Sits between testbench or CPU-side traffic and the memory, and is the only driver of the memory control signals.

---
 rtl/mem_initiator.sv | 153 +++++++++++++++
 tb/tb_mem_initiator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Burst initiator for a 32x8 single-port memory: valid/ready command port, write stream, read stream.
// Optional beat counters (wr_beats, rd_beats) are enabled by defining MEM_INIT_STATS_EN.
module mem_initiator #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_INIT_STATS_EN
    output logic [15:0]       wr_beats,
    output logic [15:0]       rd_beats,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_CAP,
        RD_RESP
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
    logic [LEN_W-1:0]  beats_left, beats_left_nx;
    logic              mem_write_nx, mem_read_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              rd_valid_nx, rd_last_nx;
    logic [DATA_W-1:0] rd_data_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
        end else begin
            state      <= state_nx;
            cur_addr   <= cur_addr_nx;
            beats_left <= beats_left_nx;
            mem_write  <= mem_write_nx;
            mem_read   <= mem_read_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            rd_valid   <= rd_valid_nx;
            rd_data    <= rd_data_nx;
            rd_last    <= rd_last_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cur_addr_nx   = cur_addr;
        beats_left_nx = beats_left;
        mem_write_nx  = 1'b0;
        mem_read_nx   = 1'b0;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        rd_valid_nx   = rd_valid;
        rd_data_nx    = rd_data;
        rd_last_nx    = rd_last;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_nx   = cmd_addr;
                    beats_left_nx = cmd_len;
                    state_nx      = cmd_write ? WR : RD_ISSUE;
                end
            end
            WR: begin
                if (wr_valid) begin
                    mem_write_nx  = 1'b1;
                    mem_addr_nx   = cur_addr;
                    mem_wdata_nx  = wr_data;
                    cur_addr_nx   = cur_addr + ADDR_W'(1);
                    beats_left_nx = beats_left - LEN_W'(1);
                    if (beats_left == '0) state_nx = IDLE;
                end
            end
            RD_ISSUE: begin
                mem_read_nx = 1'b1;
                mem_addr_nx = cur_addr;
                state_nx    = RD_WAIT;
            end
            RD_WAIT: state_nx = RD_CAP;
            RD_CAP: begin
                rd_data_nx  = mem_rdata;
                rd_valid_nx = 1'b1;
                rd_last_nx  = (beats_left == '0);
                state_nx    = RD_RESP;
            end
            RD_RESP: begin
                if (rd_ready) begin
                    rd_valid_nx = 1'b0;
                    if (rd_last) begin
                        state_nx = IDLE;
                    end else begin
                        cur_addr_nx   = cur_addr + ADDR_W'(1);
                        beats_left_nx = beats_left - LEN_W'(1);
                        state_nx      = RD_ISSUE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == WR);
    // the final write strobe still lands in the cycle after WR has returned to IDLE
    assign busy      = (state != IDLE) || mem_write;

`ifdef MEM_INIT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_beats <= '0;
            rd_beats <= '0;
        end else begin
            if (mem_write && (wr_beats != '1)) wr_beats <= wr_beats + 16'd1;
            if (rd_valid && rd_ready && (rd_beats != '1)) rd_beats <= rd_beats + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized scoreboard bench for mem_initiator with a behavioural 32x8 memory and reference array.
// Define MEM_INIT_STATS_EN to also check the beat counters.
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [2:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_ready = 1'b0;
    logic       cmd_ready, wr_ready, rd_valid, rd_last, busy, mem_write, mem_read;
    logic [7:0] rd_data, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [4:0] mem_addr;
`ifdef MEM_INIT_STATS_EN
    logic [15:0] wr_beats, rd_beats;
`endif

    always #5 clk = ~clk;

    mem_initiator #(.ADDR_W(5), .DATA_W(8), .LEN_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_INIT_STATS_EN
        .wr_beats(wr_beats), .rd_beats(rd_beats),
`endif
        .mem_rdata(mem_rdata)
    );

    // synchronous single-port memory the initiator drives
    logic [7:0] mem [32] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr];
    end

    logic [7:0]  ref_mem [32] = '{default: 8'h00};
    logic [12:0] exp_wr [$];
    logic [8:0]  exp_rd [$];
    logic [4:0]  exp_ra [$];
    logic [7:0]  wbuf [8];
    int checks = 0, fails = 0, cyc = 0, rd_hs = 0, mr_cyc = -100, rd_mode = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rd_mode)
            0: rd_ready = ($urandom_range(0, 3) != 0);
            1: rd_ready = 1'b0;
            default: rd_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops expected traffic whenever the DUT presents it
    bit pv = 0, phs = 0, exp_mw = 0;
    logic [7:0] pdata = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 0; phs = 0; exp_mw = 0;
        end else begin
            check("mem_strobe_exclusive", {31'b0, mem_write & mem_read}, 0);
            if (exp_mw) check("wr_strobe_latency", {31'b0, mem_write}, 1);
            if (mem_write) begin
                if (exp_wr.size() == 0) check("wr_unexpected", {31'b0, mem_write}, 0);
                else begin
                    logic [12:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", {27'b0, mem_addr}, {27'b0, e[12:8]});
                    check("wr_data", {24'b0, mem_wdata}, {24'b0, e[7:0]});
                end
            end
            if (mem_read) begin
                mr_cyc = cyc;
                if (exp_ra.size() == 0) check("rd_unexpected", {31'b0, mem_read}, 0);
                else check("rd_addr", {27'b0, mem_addr}, {27'b0, exp_ra.pop_front()});
            end
            if (rd_valid && !pv) check("rd_valid_latency", cyc - mr_cyc, 2);
            if (rd_valid) check("no_read_while_held", {31'b0, mem_read}, 0);
            if (rd_valid && pv && !phs) check("rd_data_hold", {24'b0, rd_data}, {24'b0, pdata});
            if (rd_valid && rd_ready) begin
                rd_hs++;
                if (exp_rd.size() == 0) check("rd_beat_unexpected", {31'b0, rd_valid}, 0);
                else begin
                    logic [8:0] e;
                    e = exp_rd.pop_front();
                    check("rd_data", {24'b0, rd_data}, {24'b0, e[7:0]});
                    check("rd_last", {31'b0, rd_last}, {31'b0, e[8]});
                end
            end
            pv = rd_valid; phs = rd_valid && rd_ready; pdata = rd_data;
            exp_mw = wr_valid && wr_ready;
        end
    end

    task automatic send_cmd(input bit w, input int a, input int len);
        int t = 0;
        while (!cmd_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (!cmd_ready) check("cmd_ready_timeout", {31'b0, cmd_ready}, 1);
        cmd_valid = 1; cmd_write = w; cmd_addr = a[4:0]; cmd_len = len[2:0];
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic do_write(input int a, input int len, input bit gaps, input bit poke);
        int t;
        bit ok = 1;
        for (int i = 0; i <= len; i++) begin
            exp_wr.push_back({5'(a + i), wbuf[i]});
            ref_mem[5'(a + i)] = wbuf[i];
        end
        send_cmd(1, a, len);
        for (int i = 0; i <= len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin wr_valid = 0; @(posedge clk); #1; end
            wr_valid = 1; wr_data = wbuf[i];
            t = 0;
            while (!wr_ready && t < 50) begin @(posedge clk); #1; t++; end
            if (!wr_ready) begin check("wr_ready_timeout", {31'b0, wr_ready}, 1); ok = 0; break; end
            if (poke && i == 1) begin
                cmd_valid = 1; cmd_write = $urandom_range(0, 1);
                cmd_addr = 5'($urandom); cmd_len = 3'($urandom);
                check("cmd_ready_in_wr", {31'b0, cmd_ready}, 0);
            end
            @(posedge clk); #1;
            cmd_valid = 0;
        end
        wr_valid = 0;
        if (ok) check("ready_after_last_wr", {31'b0, cmd_ready}, 1);
    endtask

    task automatic do_read(input int a, input int len, input bit wait_done);
        int t = 0, target;
        for (int i = 0; i <= len; i++) begin
            exp_ra.push_back(5'(a + i));
            exp_rd.push_back({i == len, ref_mem[5'(a + i)]});
        end
        target = rd_hs + len + 1;
        send_cmd(0, a, len);
        @(posedge clk); #1;
        check("cmd_to_mem_read", {31'b0, mem_read}, 1);
        if (wait_done) begin
            while (rd_hs < target && t < 2000) begin @(posedge clk); #1; t++; end
            check("rd_burst_complete", {31'b0, rd_hs >= target}, 1);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {4'b0, cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, mem_write, mem_read, mem_addr, mem_wdata},
              {4'b0, 1'b1, 27'b0});
        rst_n = 1;
        @(posedge clk); #1;

        // basic burst
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
        do_write(3, 3, 0, 0);
        do_read(3, 3, 1);

        // wrap past address 31
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_write(30, 3, 0, 0);
        do_read(30, 3, 1);

        // consumer stall holds the read beat
        wbuf[0] = 8'h5A;
        do_write(5, 0, 0, 0);
        rd_mode = 1;
        do_read(5, 0, 0);
        t = 0;
        while (!rd_valid && t < 20) begin @(posedge clk); #1; t++; end
        repeat (6) begin
            @(posedge clk); #1;
            check("stall_rd_valid", {31'b0, rd_valid}, 1);
            check("stall_rd_data", {24'b0, rd_data}, 32'h5A);
            check("stall_no_mem_read", {31'b0, mem_read}, 0);
        end
        rd_mode = 0;

        // command offered during a write burst is dropped
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(20, 3, 0, 1);
        do_read(20, 3, 1);

        // randomized bursts
        for (int n = 0; n < 24; n++) begin
            int a, len;
            a = $urandom_range(0, 31); len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
                do_write(a, len, $urandom_range(0, 1) == 1, 0);
            end else begin
                do_read(a, len, 1);
            end
        end

        // reset in the middle of an 8-beat read
        rd_mode = 2;
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(8, 7, 0, 0);
        begin
            int base;
            base = rd_hs;
            do_read(8, 7, 0);
            t = 0;
            while (rd_hs < base + 2 && t < 100) begin @(posedge clk); #1; t++; end
            check("two_beats_before_reset", {31'b0, rd_hs >= base + 2}, 1);
        end
        #1 rst_n = 0;
        #1;
        check("mid_burst_reset_outputs",
              {4'b0, cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, mem_write, mem_read, mem_addr, mem_wdata},
              {4'b0, 1'b1, 27'b0});
        exp_rd.delete();
        exp_ra.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // fresh traffic after reset: 4-beat write then 2-beat read
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(12, 3, 0, 0);
        do_read(12, 1, 1);
`ifdef MEM_INIT_STATS_EN
        check("wr_beats", {16'b0, wr_beats}, 4);
        check("rd_beats", {16'b0, rd_beats}, 2);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", {31'b0, busy}, 0);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("ra_queue_drained", exp_ra.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
